// File: rtl/coeff_stream_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// coeff_stream_unpacker_pkg
// Shared definitions for the coefficient packet stream: header sync byte,
// header field bit positions, packet length and the unpacker state encoding.
// The output parser imports the same package, so the header format is
// defined in one place only.
//
// Optional feature macro: UNPACK_CHECKSUM_EN (adds a trailing XOR word).
// -----------------------------------------------------------------------------
package coeff_stream_unpacker_pkg;

  // Header word layout
  localparam logic [7:0] HDR_SYNC_BYTE = 8'hA5;
  localparam int SYNC_HI       = 31;
  localparam int SYNC_LO       = 24;
  localparam int MODE_HI       = 23;
  localparam int MODE_LO       = 22;
  localparam int MBX_HI        = 21;
  localparam int MBX_LO        = 16;
  localparam int MBY_HI        = 15;
  localparam int MBY_LO        = 10;
  localparam int IDX_HI        = 9;
  localparam int IDX_LO        = 6;
  localparam int FRAME_END_BIT = 0;

  // Packet length: one header, four payload words, optionally one checksum word
  localparam int PKT_DATA_WORDS = 4;
`ifdef UNPACK_CHECKSUM_EN
  localparam int PKT_WORDS = PKT_DATA_WORDS + 2;
`else
  localparam int PKT_WORDS = PKT_DATA_WORDS + 1;
`endif

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Decoded header tag fields
  typedef struct packed {
    logic [1:0] mode;
    logic [5:0] mb_x;
    logic [5:0] mb_y;
    logic [3:0] idx;
    logic       frame_end;
  } hdr_t;

endpackage

// File: rtl/coeff_stream_unpacker_if.sv
// -----------------------------------------------------------------------------
// coeff_stream_unpacker_if
// Bundles the word-FIFO read port and the block output handshake of the
// unpacker.
//   master : the unpacker side (pops the FIFO, drives the block)
//   slave  : the environment side (FIFO source and block consumer)
// Signals:
//   fifo_empty / fifo_rd_en / fifo_dout / fifo_valid : FIFO read port
//   blk_flat / blk_valid / blk_ready                  : block handshake
//   blk_mode / blk_mb_x / blk_mb_y / blk_idx          : block tags
//   frame_complete                                    : end-of-frame pulse
// -----------------------------------------------------------------------------
interface coeff_stream_unpacker_if;

  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [31:0]  fifo_dout;
  logic         fifo_valid;

  logic [127:0] blk_flat;
  logic         blk_valid;
  logic         blk_ready;
  logic [1:0]   blk_mode;
  logic [5:0]   blk_mb_x;
  logic [5:0]   blk_mb_y;
  logic [3:0]   blk_idx;
  logic         frame_complete;

  modport master (
    input  fifo_empty, fifo_dout, fifo_valid, blk_ready,
    output fifo_rd_en, blk_flat, blk_valid, blk_mode, blk_mb_x, blk_mb_y,
           blk_idx, frame_complete
  );

  modport slave (
    output fifo_empty, fifo_dout, fifo_valid, blk_ready,
    input  fifo_rd_en, blk_flat, blk_valid, blk_mode, blk_mb_x, blk_mb_y,
           blk_idx, frame_complete
  );

endinterface

// File: rtl/coeff_stream_unpacker_hdr_decode.sv
// -----------------------------------------------------------------------------
// coeff_stream_unpacker_hdr_decode
// Combinational split of a header word into its tag fields plus the sync
// byte compare.
// Ports:
//   hdr_word : candidate header word from the FIFO
//   fields   : mode, mb_x, mb_y, idx, frame_end
//   sync_ok  : high when bits [31:24] equal SYNC_BYTE
// Bits [5:1] are reserved and ignored.
// -----------------------------------------------------------------------------
module coeff_stream_unpacker_hdr_decode
  import coeff_stream_unpacker_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = HDR_SYNC_BYTE
) (
  input  logic [31:0] hdr_word,
  output hdr_t        fields,
  output logic        sync_ok
);

  logic unused_rsvd_s;

  // Field split and sync compare
  always_comb begin
    fields.mode      = hdr_word[MODE_HI:MODE_LO];
    fields.mb_x      = hdr_word[MBX_HI:MBX_LO];
    fields.mb_y      = hdr_word[MBY_HI:MBY_LO];
    fields.idx       = hdr_word[IDX_HI:IDX_LO];
    fields.frame_end = hdr_word[FRAME_END_BIT];
    sync_ok          = (hdr_word[SYNC_HI:SYNC_LO] == SYNC_BYTE);
  end

  // Reserved bits are deliberately ignored
  assign unused_rsvd_s = ^hdr_word[IDX_LO-1:FRAME_END_BIT+1];

endmodule

// File: rtl/coeff_stream_unpacker.sv
// -----------------------------------------------------------------------------
// coeff_stream_unpacker
// Pops 32-bit words from a word FIFO, validates a header word (sync byte),
// reassembles the following payload words into one 128-bit 4x4 block and
// presents it with a valid/ready handshake, tagged with mode, macroblock
// coordinates and block index. frame_complete pulses when a block whose
// header frame_end bit was set is accepted.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (master)  : FIFO read port and block output handshake
//   sync_err_cnt  : saturating count of rejected header (or checksum) words
//   busy          : high unless idle in HDR with no read outstanding
//
// Build option: `define UNPACK_CHECKSUM_EN to expect a sixth word per packet
// holding the XOR of header and payload; mismatching packets are dropped.
// -----------------------------------------------------------------------------
module coeff_stream_unpacker
  import coeff_stream_unpacker_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = HDR_SYNC_BYTE,
  parameter int         DATA_WORDS = PKT_DATA_WORDS,
  parameter int         ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  coeff_stream_unpacker_if.master bus,
  output logic [ERR_CNT_W-1:0]    sync_err_cnt,
  output logic                    busy
);

  localparam logic [1:0] LAST_WORD = 2'(DATA_WORDS - 1);

  state_e               state_q, state_d;
  logic                 outstanding_q, outstanding_d;
  logic [1:0]           word_cnt_q, word_cnt_d;
  logic [127:0]         blk_flat_q, blk_flat_d;
  hdr_t                 hdr_q, hdr_d;
  logic                 blk_valid_q, blk_valid_d;
  logic                 frame_complete_q, frame_complete_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 busy_q, busy_d;
`ifdef UNPACK_CHECKSUM_EN
  logic [31:0]          chk_acc_q, chk_acc_d;
`endif

  hdr_t hdr_s;
  logic sync_ok_s;
  logic read_state_s;
  logic rd_en_s;
  logic word_acc_s;

  // Increment that sticks at all-ones
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  coeff_stream_unpacker_hdr_decode #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_hdr_decode (
    .hdr_word (bus.fifo_dout),
    .fields   (hdr_s),
    .sync_ok  (sync_ok_s)
  );

  // Read issue, next-state and datapath update
  always_comb begin
    state_d          = state_q;
    outstanding_d    = outstanding_q;
    word_cnt_d       = word_cnt_q;
    blk_flat_d       = blk_flat_q;
    hdr_d            = hdr_q;
    blk_valid_d      = blk_valid_q;
    frame_complete_d = 1'b0;
    err_cnt_d        = err_cnt_q;
`ifdef UNPACK_CHECKSUM_EN
    chk_acc_d        = chk_acc_q;
    read_state_s     = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
`else
    read_state_s     = (state_q == HDR) || (state_q == DATA);
`endif

    // Only one read in flight; a word is taken only when we asked for it,
    // which also discards a stray fifo_valid right after reset.
    rd_en_s    = !bus.fifo_empty && read_state_s && !outstanding_q;
    word_acc_s = bus.fifo_valid && outstanding_q;

    if (rd_en_s) begin
      outstanding_d = 1'b1;
    end else if (word_acc_s) begin
      outstanding_d = 1'b0;
    end else begin
      outstanding_d = outstanding_q;
    end

    case (state_q)
      HDR: begin
        if (word_acc_s) begin
          if (sync_ok_s) begin
            hdr_d      = hdr_s;
            word_cnt_d = 2'd0;
            state_d    = DATA;
`ifdef UNPACK_CHECKSUM_EN
            chk_acc_d  = bus.fifo_dout;
`endif
          end else begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end else begin
          state_d = HDR;
        end
      end

      DATA: begin
        if (word_acc_s) begin
          // Slot k occupies bits [127-32k : 96-32k]
          case (word_cnt_q)
            2'd0:    blk_flat_d[127:96] = bus.fifo_dout;
            2'd1:    blk_flat_d[95:64]  = bus.fifo_dout;
            2'd2:    blk_flat_d[63:32]  = bus.fifo_dout;
            2'd3:    blk_flat_d[31:0]   = bus.fifo_dout;
            default: blk_flat_d         = blk_flat_q;
          endcase
          word_cnt_d = word_cnt_q + 2'd1;
`ifdef UNPACK_CHECKSUM_EN
          chk_acc_d  = chk_acc_q ^ bus.fifo_dout;
`endif
          if (word_cnt_q == LAST_WORD) begin
`ifdef UNPACK_CHECKSUM_EN
            state_d     = CHK;
`else
            state_d     = OUT;
            blk_valid_d = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end

`ifdef UNPACK_CHECKSUM_EN
      CHK: begin
        if (word_acc_s) begin
          if (bus.fifo_dout == chk_acc_q) begin
            state_d     = OUT;
            blk_valid_d = 1'b1;
          end else begin
            // Corrupt packet: drop the block silently apart from the counter
            state_d   = HDR;
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end else begin
          state_d = CHK;
        end
      end
`endif

      OUT: begin
        if (blk_valid_q && bus.blk_ready) begin
          blk_valid_d      = 1'b0;
          frame_complete_d = hdr_q.frame_end;
          state_d          = HDR;
        end else begin
          state_d = OUT;
        end
      end

      default: begin
        state_d     = HDR;
        blk_valid_d = 1'b0;
      end
    endcase

    busy_d = !((state_d == HDR) && !outstanding_d);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= HDR;
      outstanding_q    <= 1'b0;
      word_cnt_q       <= 2'd0;
      blk_flat_q       <= 128'd0;
      hdr_q            <= '0;
      blk_valid_q      <= 1'b0;
      frame_complete_q <= 1'b0;
      err_cnt_q        <= '0;
      busy_q           <= 1'b0;
`ifdef UNPACK_CHECKSUM_EN
      chk_acc_q        <= 32'd0;
`endif
    end else begin
      state_q          <= state_d;
      outstanding_q    <= outstanding_d;
      word_cnt_q       <= word_cnt_d;
      blk_flat_q       <= blk_flat_d;
      hdr_q            <= hdr_d;
      blk_valid_q      <= blk_valid_d;
      frame_complete_q <= frame_complete_d;
      err_cnt_q        <= err_cnt_d;
      busy_q           <= busy_d;
`ifdef UNPACK_CHECKSUM_EN
      chk_acc_q        <= chk_acc_d;
`endif
    end
  end

  assign bus.fifo_rd_en     = rd_en_s;
  assign bus.blk_flat       = blk_flat_q;
  assign bus.blk_valid      = blk_valid_q;
  assign bus.blk_mode       = hdr_q.mode;
  assign bus.blk_mb_x       = hdr_q.mb_x;
  assign bus.blk_mb_y       = hdr_q.mb_y;
  assign bus.blk_idx        = hdr_q.idx;
  assign bus.frame_complete = frame_complete_q;
  assign sync_err_cnt       = err_cnt_q;
  assign busy               = busy_q;

endmodule
